// File: rtl/audio_out_fader_if.sv
// Sample-source and Audio_Controller write-port signals of the output fader.
// The master drives the sources and write-allowed flag; the slave (fader) drives the output.
interface audio_out_fader_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        mode;
    logic              wao_tone;
    logic [DATA_W-1:0] sound_tone;
    logic              wao_metro;
    logic [DATA_W-1:0] sound_metro;
    logic              audio_out_allowed;
    logic              write_audio_out;
    logic [DATA_W-1:0] sound;
    logic              busy;

    modport master (
        output mode, wao_tone, sound_tone, wao_metro, sound_metro, audio_out_allowed,
        input  write_audio_out, sound, busy
    );

    modport slave (
        input  mode, wao_tone, sound_tone, wao_metro, sound_metro, audio_out_allowed,
        output write_audio_out, sound, busy
    );
endinterface

// File: rtl/audio_out_fader.sv
// Click-free audio output arbiter: selects tone/metronome by mode, scales by a ramped gain,
// and fades the old source out before fading the new one in.
//
//   state    | meaning
//   MUTE     | no active source, gain 0, output held at 0
//   FADE_IN  | gain steps up by one per written sample until unity
//   RUN      | active source passes through at unity gain
//   FADE_OUT | gain steps down per written sample; at 0 switch source or mute
module audio_out_fader #(
    parameter int DATA_W      = 32,
    parameter int GAIN_BITS   = 6,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic CLOCK_50,
    input  logic resetn,
    audio_out_fader_if.slave aud
);
    localparam int GW = GAIN_BITS + 1;
    localparam int PW = DATA_W + GAIN_BITS + 1;
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [GW-1:0] UNITY    = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {MUTE, FADE_IN, RUN, FADE_OUT} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_TONE, SRC_METRO} src_t;

    state_t state, state_next;
    src_t   active, active_next, target;
    logic [GW-1:0] gain, gain_next;
    logic [CW-1:0] tmo_cnt;
    logic          src_wao, strobe, fading, tmo;
    logic signed [DATA_W-1:0] sample_sel;
    logic signed [PW-1:0]     prod;
    logic [DATA_W-1:0]        sound_next;

    always_comb begin
        target = SRC_NONE;
        case (aud.mode)
            2'b00:   target = SRC_TONE;
            2'b01:   target = SRC_METRO;
            default: target = SRC_NONE;
        endcase
    end

    always_comb begin
        src_wao    = 1'b0;
        sample_sel = '0;
        case (active)
            SRC_TONE: begin
                src_wao    = aud.wao_tone;
                sample_sel = $signed(aud.sound_tone);
            end
            SRC_METRO: begin
                src_wao    = aud.wao_metro;
                sample_sel = $signed(aud.sound_metro);
            end
            default: begin
                src_wao    = 1'b0;
                sample_sel = '0;
            end
        endcase
    end

    assign strobe = src_wao & aud.audio_out_allowed;
    assign fading = (state == FADE_IN) || (state == FADE_OUT);
    assign tmo    = fading && (tmo_cnt == TMO_LAST);

    // Zero-extended gain keeps the multiply signed without flipping the sample sign.
    always_comb begin
        prod       = PW'(sample_sel) * $signed({{(PW-GW){1'b0}}, gain});
        sound_next = prod[GAIN_BITS +: DATA_W];
    end

    always_comb begin
        state_next  = state;
        active_next = active;
        case (state)
            MUTE: begin
                if (target != SRC_NONE) begin
                    active_next = target;
                    state_next  = FADE_IN;
                end
            end
            FADE_IN: begin
                if (target != active)   state_next = FADE_OUT;
                else if (gain == UNITY) state_next = RUN;
            end
            RUN: begin
                if (target != active) state_next = FADE_OUT;
            end
            FADE_OUT: begin
                if (gain == '0) begin
                    active_next = target;
                    state_next  = (target == SRC_NONE) ? MUTE : FADE_IN;
                end else if (target == active) begin
                    state_next = FADE_IN;
                end
            end
            default: begin
                state_next  = MUTE;
                active_next = SRC_NONE;
            end
        endcase
    end

    always_comb begin
        gain_next = gain;
        case (state)
            MUTE:     gain_next = '0;
            RUN:      gain_next = UNITY;
            FADE_IN: begin
                if (tmo)                          gain_next = UNITY;
                else if (strobe && gain != UNITY) gain_next = gain + 1'b1;
            end
            FADE_OUT: begin
                if (tmo)                       gain_next = '0;
                else if (strobe && gain != '0) gain_next = gain - 1'b1;
            end
            default:  gain_next = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state               <= MUTE;
            active              <= SRC_NONE;
            gain                <= '0;
            tmo_cnt             <= '0;
            aud.write_audio_out <= 1'b0;
            aud.sound           <= '0;
        end else begin
            state               <= state_next;
            active              <= active_next;
            gain                <= gain_next;
            aud.write_audio_out <= strobe;
            if (strobe)
                aud.sound <= sound_next;
            else if (state_next == MUTE)
                aud.sound <= '0;
            if (strobe || tmo || (state_next != state))
                tmo_cnt <= '0;
            else if (fading)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
        end
    end

    assign aud.busy = fading;
endmodule

// File: tb/tb_audio_out_fader.sv
// Scoreboard bench for audio_out_fader: stimulus queues expected samples, a negedge
// monitor pops them on each write strobe; state-level results are checked directly.
module tb_audio_out_fader;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   passes = 0;
    logic [31:0] exp_q[$];

    audio_out_fader_if #(.DATA_W(32)) aud();

    audio_out_fader #(.DATA_W(32), .GAIN_BITS(6), .TIMEOUT_CYC(4096)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .aud      (aud.slave)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && aud.write_audio_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got write with sound %h, want no write", aud.sound);
            end else begin
                check("write_sound", aud.sound, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One strobe cycle followed by one idle cycle; the write lands during the idle cycle.
    task automatic send(input bit metro, input logic [31:0] data, input bit allow,
                        input bit expect_write, input logic [31:0] exp);
        aud.audio_out_allowed = allow;
        if (metro) begin
            aud.wao_metro   = 1'b1;
            aud.sound_metro = data;
        end else begin
            aud.wao_tone   = 1'b1;
            aud.sound_tone = data;
        end
        if (expect_write) exp_q.push_back(exp);
        tick(1);
        aud.wao_tone          = 1'b0;
        aud.wao_metro         = 1'b0;
        aud.audio_out_allowed = 1'b1;
        tick(1);
    endtask

    initial begin
        int n;
        aud.mode              = 2'b10;
        aud.wao_tone          = 1'b0;
        aud.sound_tone        = '0;
        aud.wao_metro         = 1'b0;
        aud.sound_metro       = '0;
        aud.audio_out_allowed = 1'b1;
        #15;
        check("reset_write", {31'd0, aud.write_audio_out}, 32'd0);
        check("reset_sound", aud.sound, 32'd0);
        check("reset_busy", {31'd0, aud.busy}, 32'd0);
        tick(2);
        resetn = 1'b1;
        tick(2);
        check("mute_idle_busy", {31'd0, aud.busy}, 32'd0);

        // Fade in tone: k-th write uses gain k before its step.
        aud.mode = 2'b00;
        tick(1);
        check("fade_in_busy", {31'd0, aud.busy}, 32'd1);
        for (int k = 0; k < 64; k++) send(1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h40 * k);
        check("run_busy", {31'd0, aud.busy}, 32'd0);
        send(1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1000);
        send(1'b0, 32'hFFFF_E000, 1'b1, 1'b1, 32'hFFFF_E000);

        // Tone -> metronome crossfade; a stray metro strobe during fade-out is ignored.
        aud.mode = 2'b01;
        tick(1);
        check("xfade_busy", {31'd0, aud.busy}, 32'd1);
        for (int k = 0; k < 64; k++) begin
            send(1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h40 * (64 - k));
            if (k == 10) send(1'b1, 32'h0000_0800, 1'b1, 1'b0, 32'd0);
        end
        check("metro_fade_in_busy", {31'd0, aud.busy}, 32'd1);
        for (int k = 0; k < 64; k++) send(1'b1, 32'h0000_0800, 1'b1, 1'b1, 32'h20 * k);
        check("metro_run_busy", {31'd0, aud.busy}, 32'd0);

        // Metronome -> tuner mute; sources keep pulsing but nothing is written.
        aud.mode = 2'b10;
        tick(1);
        for (int k = 0; k < 64; k++) send(1'b1, 32'h0000_0800, 1'b1, 1'b1, 32'h20 * (64 - k));
        check("mute_busy", {31'd0, aud.busy}, 32'd0);
        check("mute_sound", aud.sound, 32'd0);
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 32'h0000_1234, 1'b1, 1'b0, 32'd0);
            send(1'b1, 32'h0000_5678, 1'b1, 1'b0, 32'd0);
        end
        check("mute_sound_hold", aud.sound, 32'd0);

        // Writes blocked by audio_out_allowed=0 are dropped and do not step the gain.
        aud.mode = 2'b00;
        tick(1);
        for (int k = 0; k < 3; k++) send(1'b0, 32'h0000_1000, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 32; k++) send(1'b0, 32'h0000_0040, 1'b1, 1'b1, k);
        for (int k = 0; k < 2; k++) send(1'b0, 32'h0000_1000, 1'b0, 1'b0, 32'd0);
        send(1'b0, 32'hFFFF_E000, 1'b1, 1'b1, 32'hFFFF_F000);

        // Fade-out from gain 33 with the source stalled: timeout snaps gain to 0, then MUTE.
        aud.mode = 2'b10;
        tick(1);
        send(1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0840);
        send(1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0800);
        send(1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_07C0);
        tick(3900);
        check("stall_busy_early", {31'd0, aud.busy}, 32'd1);
        n = 3900;
        while (aud.busy === 1'b1 && n < 4300) begin
            tick(1);
            n++;
        end
        check("timeout_cycles", n, 4096);
        check("timeout_busy", {31'd0, aud.busy}, 32'd0);
        check("timeout_sound", aud.sound, 32'd0);

        // Reset in the middle of a fade-in at gain 20.
        aud.mode = 2'b00;
        tick(1);
        for (int k = 0; k < 20; k++) send(1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h40 * k);
        check("pre_reset_sound", aud.sound, 32'h0000_04C0);
        #5;
        resetn = 1'b0;
        #1;
        check("mid_reset_write", {31'd0, aud.write_audio_out}, 32'd0);
        check("mid_reset_sound", aud.sound, 32'd0);
        check("mid_reset_busy", {31'd0, aud.busy}, 32'd0);
        tick(2);
        resetn = 1'b1;
        tick(1);
        check("restart_busy", {31'd0, aud.busy}, 32'd1);
        for (int k = 0; k < 3; k++) send(1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h40 * k);

        tick(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish after 100000 cycles, want finish");
        $fatal(1);
    end
endmodule
